// File: rtl/sdu_print_pkg.sv
// Shared types and constants for the SDU print transmit path.
package sdu_print_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SEND = 3'd1,
        CR   = 3'd2,
        LF   = 3'd3,
        ACK  = 3'd4
    } state_t;

    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam int         WORD_DIGITS = 8;

endpackage

// File: rtl/hex2char.sv
// Nibble to ASCII hex digit; inverse of the receive-side char-to-hex converter.
module hex2char
    import sdu_print_pkg::*;
#(
    parameter bit HEX_UPPER = 1'b1
) (
    input  logic [3:0] nib,
    output logic [7:0] chr
);

    localparam logic [7:0] ALPHA_BASE = HEX_UPPER ? 8'h41 : 8'h61;

    always_comb begin
        if (nib < 4'd10) chr = ASCII_0 + {4'h0, nib};
        else             chr = ALPHA_BASE + {4'h0, nib} - 8'd10;
    end

endmodule

// File: rtl/print_tx.sv
// CPU debug byte/word to UART character streamer (raw byte or 8 hex digits, MSN first).
// Optional CR/LF after word output: define PRINT_CRLF_EN.
module print_tx
    import sdu_print_pkg::*;
#(
    parameter bit HEX_UPPER = 1'b1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] dout_tx,
    input  logic        type_tx,
    input  logic        req_tx,
    output logic        ack_tx,
    output logic        busy_tx,
    output logic [7:0]  d_tx,
    output logic        vld_tx,
    input  logic        rdy_tx
);

    state_t      state, state_nxt;
    logic [31:0] data_q;
    logic        typ_q;
    logic [3:0]  cnt_q;
    logic [2:0]  nib_idx;
    logic [3:0]  nib;
    logic [7:0]  hex_c;

    // cnt counts digits remaining, so the current nibble sits at 4*(cnt-1)
    assign nib_idx = 3'(cnt_q - 4'd1);
    assign nib     = data_q[{nib_idx, 2'b00} +: 4];

    hex2char #(.HEX_UPPER(HEX_UPPER)) u_hex2char (
        .nib (nib),
        .chr (hex_c)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_q <= '0;
            typ_q  <= 1'b0;
            cnt_q  <= '0;
        end else if (state == IDLE && req_tx) begin
            data_q <= dout_tx;
            typ_q  <= type_tx;
            cnt_q  <= type_tx ? 4'(WORD_DIGITS) : 4'd1;
        end else if (state == SEND && rdy_tx) begin
            cnt_q  <= cnt_q - 4'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        ack_tx    = 1'b0;
        busy_tx   = 1'b1;
        vld_tx    = 1'b0;
        d_tx      = 8'h00;
        case (state)
            IDLE: begin
                busy_tx = 1'b0;
                if (req_tx) state_nxt = SEND;
            end
            SEND: begin
                vld_tx = 1'b1;
                d_tx   = typ_q ? hex_c : data_q[7:0];
                if (rdy_tx && cnt_q == 4'd1) begin
`ifdef PRINT_CRLF_EN
                    state_nxt = typ_q ? CR : ACK;
`else
                    state_nxt = ACK;
`endif
                end
            end
`ifdef PRINT_CRLF_EN
            CR: begin
                vld_tx = 1'b1;
                d_tx   = ASCII_CR;
                if (rdy_tx) state_nxt = LF;
            end
            LF: begin
                vld_tx = 1'b1;
                d_tx   = ASCII_LF;
                if (rdy_tx) state_nxt = ACK;
            end
`endif
            ACK: begin
                ack_tx    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_print_tx.sv
// Directed self-checking bench for print_tx (upper-case and lower-case hex instances).
module tb_print_tx;

`ifdef PRINT_CRLF_EN
    localparam int NCH = 10;
`else
    localparam int NCH = 8;
`endif

    logic        clk, rstn;
    logic [31:0] dout_tx, dout2;
    logic        type_tx, type2, req_tx, req2, rdy_tx, rdy2;
    logic        ack_tx, busy_tx, vld_tx, ack2, busy2, vld2;
    logic [7:0]  d_tx, d2;

    print_tx #(.HEX_UPPER(1'b1)) u_dut (
        .clk(clk), .rstn(rstn), .dout_tx(dout_tx), .type_tx(type_tx), .req_tx(req_tx),
        .ack_tx(ack_tx), .busy_tx(busy_tx), .d_tx(d_tx), .vld_tx(vld_tx), .rdy_tx(rdy_tx)
    );

    print_tx #(.HEX_UPPER(1'b0)) u_lc (
        .clk(clk), .rstn(rstn), .dout_tx(dout2), .type_tx(type2), .req_tx(req2),
        .ack_tx(ack2), .busy_tx(busy2), .d_tx(d2), .vld_tx(vld2), .rdy_tx(rdy2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] q[$];
    logic [7:0] q2[$];
    int         ack_cnt  = 0;
    int         stab_err = 0;
    logic       held     = 1'b0;
    logic [7:0] held_d   = 8'h00;

    // Transfer log and hold-stability monitor
    always @(posedge clk) begin
        if (rstn) begin
            if (vld_tx && rdy_tx) q.push_back(d_tx);
            if (vld2 && rdy2)     q2.push_back(d2);
            if (ack_tx)           ack_cnt <= ack_cnt + 1;
            if (held && vld_tx && d_tx !== held_d) stab_err <= stab_err + 1;
            held   <= vld_tx && !rdy_tx;
            held_d <= d_tx;
        end else begin
            held <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [7:0] exp_w [0:9];
    bit         pat   [0:19];
    int         base, base2, a0, nb;
    bit         got;

    initial begin
        rstn = 1'b0; dout_tx = '0; type_tx = 0; req_tx = 0; rdy_tx = 0;
        dout2 = '0; type2 = 0; req2 = 0; rdy2 = 0;
        #12;
        check("rst_vld", vld_tx, 1'b0);
        check("rst_d", d_tx, 8'h00);
        check("rst_ack", ack_tx, 1'b0);
        check("rst_busy", busy_tx, 1'b0);
        check("rst_vld_lc", vld2, 1'b0);
        @(negedge clk); rstn = 1'b1;
        @(negedge clk);

        // 1: byte 'A', ack two cycles after request
        base = q.size();
        dout_tx = 32'h0000_0041; type_tx = 0; req_tx = 1; rdy_tx = 1;
        @(negedge clk); req_tx = 0;
        check("b_vld", vld_tx, 1'b1);
        check("b_d", d_tx, 8'h41);
        check("b_busy", busy_tx, 1'b1);
        check("b_ack_early", ack_tx, 1'b0);
        @(negedge clk);
        check("b_ack", ack_tx, 1'b1);
        check("b_vld_ack", vld_tx, 1'b0);
        @(negedge clk);
        check("b_ack_pulse", ack_tx, 1'b0);
        check("b_idle", busy_tx, 1'b0);
        check("b_count", q.size() - base, 1);
        check("b_char", q[base], 8'h41);

        // 2: word 1234ABCD, one char per cycle
        exp_w = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h41, 8'h42, 8'h43, 8'h44, 8'h0D, 8'h0A};
        dout_tx = 32'h1234_ABCD; type_tx = 1; req_tx = 1;
        @(negedge clk); req_tx = 0;
        for (int i = 0; i < NCH; i++) begin
            check($sformatf("w_vld%0d", i), vld_tx, 1'b1);
            check($sformatf("w_d%0d", i), d_tx, exp_w[i]);
            @(negedge clk);
        end
        check("w_ack", ack_tx, 1'b1);
        @(negedge clk);
        check("w_idle", busy_tx, 1'b0);

        // 3: backpressure on DEADBEEF with a 5-cycle stall mid-stream
        exp_w = '{8'h44, 8'h45, 8'h41, 8'h44, 8'h42, 8'h45, 8'h45, 8'h46, 8'h0D, 8'h0A};
        pat   = '{1, 0, 1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 1, 1, 1, 0, 1, 0, 1, 1};
        base = q.size();
        dout_tx = 32'hDEAD_BEEF; type_tx = 1; req_tx = 1; rdy_tx = 0;
        @(negedge clk); req_tx = 0;
        got = 0;
        for (int c = 0; c < 60; c++) begin
            rdy_tx = (c < 20) ? pat[c] : 1'b1;
            @(negedge clk);
            if (ack_tx) begin got = 1; break; end
        end
        rdy_tx = 1;
        check("bp_ack", got, 1'b1);
        check("bp_stable", stab_err, 0);
        check("bp_count", q.size() - base, NCH);
        for (int i = 0; i < NCH; i++) check($sformatf("bp_d%0d", i), q[base + i], exp_w[i]);
        @(negedge clk);

        // 4: request while busy is dropped
        base = q.size(); a0 = ack_cnt;
        dout_tx = 32'h0; type_tx = 1; req_tx = 1;
        @(negedge clk); req_tx = 0;
        @(negedge clk); dout_tx = 32'hFFFF_FFFF; req_tx = 1;
        @(negedge clk); req_tx = 0;
        got = 0; nb = 0;
        for (int c = 0; c < 30; c++) begin
            if (ack_tx) begin got = 1; break; end
            if (!busy_tx) nb++;
            @(negedge clk);
        end
        check("bi_ack", got, 1'b1);
        check("bi_busy", nb, 0);
        repeat (3) @(negedge clk);
        check("bi_single_ack", ack_cnt - a0, 1);
        check("bi_count", q.size() - base, NCH);
        for (int i = 0; i < 8; i++) check($sformatf("bi_d%0d", i), q[base + i], 8'h30);

        // 5: reset after the third digit, then a byte 0x0D
        base = q.size(); a0 = ack_cnt;
        dout_tx = 32'h89AB_CDEF; type_tx = 1; req_tx = 1;
        @(negedge clk); req_tx = 0;
        repeat (3) @(negedge clk);
        rstn = 1'b0;
        #1;
        check("r_vld", vld_tx, 1'b0);
        check("r_busy", busy_tx, 1'b0);
        check("r_d", d_tx, 8'h00);
        check("r_partial", q.size() - base, 3);
        repeat (2) @(negedge clk);
        check("r_no_ack", ack_cnt - a0, 0);
        rstn = 1'b1;
        @(negedge clk);
        base2 = q.size();
        dout_tx = 32'h0000_000D; type_tx = 0; req_tx = 1;
        @(negedge clk); req_tx = 0;
        check("r_byte_d", d_tx, 8'h0D);
        @(negedge clk);
        check("r_byte_ack", ack_tx, 1'b1);
        @(negedge clk);
        check("r_byte_count", q.size() - base2, 1);
        check("r_byte_char", q[base2], 8'h0D);

        // 6: lower-case instance, word 000000FA
        dout2 = 32'h0000_00FA; type2 = 1; rdy2 = 1; req2 = 1;
        @(negedge clk); req2 = 0;
        got = 0;
        for (int c = 0; c < 30; c++) begin
            if (ack2) begin got = 1; break; end
            @(negedge clk);
        end
        check("lc_ack", got, 1'b1);
        check("lc_count", q2.size(), NCH);
        check("lc_d0", q2[0], 8'h30);
        check("lc_d6", q2[6], 8'h66);
        check("lc_d7", q2[7], 8'h61);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
